// File: rtl/sprite_rom_arbiter_pkg.sv
// rtl/sprite_rom_arbiter_pkg.sv - shared sprite memory widths, latency and port constants
package sprite_rom_arbiter_pkg;

    localparam int SPRITE_ADDR_W  = 10;
    localparam int SPRITE_ELEM_W  = 3;
    localparam int RGB_W          = 12;
    localparam int SPRITE_MEM_LAT = 1;
    localparam int SPRITE_STARVE  = 1023;
    localparam int REQ_PIXEL      = 0;

    // Round-robin successor among the low-priority ports 1..n_req-1.
    function automatic int rr_next(input int k, input int n_req);
        return (k >= n_req - 1) ? 1 : k + 1;
    endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// rtl/sprite_rom_arbiter_rr_pick.sv - combinational round-robin one-hot picker with wrap search
module sprite_rom_arbiter_rr_pick #(
    parameter int N     = 2,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     pick
);

    int   base;
    int   idx;
    logic found;

    // ptr names a port 1..N; bit j of req belongs to port j+1.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        base  = (ptr == '0) ? 0 : int'(ptr) - 1;
        for (int off = 0; off < N; off++) begin
            idx = (base + off) % N;
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - priority/round-robin arbiter for the sprite memory read port
module sprite_rom_arbiter
    import sprite_rom_arbiter_pkg::*;
#(
    parameter int N_REQ      = 3,
    parameter int ADDR_W     = SPRITE_ADDR_W,
    parameter int ELEM_W     = SPRITE_ELEM_W,
    parameter int DATA_W     = RGB_W,
    parameter int MEM_LAT    = SPRITE_MEM_LAT,
    parameter int STARVE_MAX = SPRITE_STARVE
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*ELEM_W-1:0]   req_elem,
    output logic [N_REQ-1:0]          gnt,
    output logic                      mem_en,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [ELEM_W-1:0]         mem_elem,
    input  logic [DATA_W-1:0]         mem_data,
    output logic [N_REQ-1:0]          rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic [N_REQ-1:0]          starve
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [IDX_W-1:0]  rr_ptr;
    logic [N_REQ-2:0]  low_pick;
    logic [IDX_W-1:0]  gnt_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [ELEM_W-1:0] sel_elem;
    logic [IDX_W-1:0]  issue_idx;
    logic [MEM_LAT-1:0] tag_v;
    logic [IDX_W-1:0]  tag_idx [MEM_LAT];

    sprite_rom_arbiter_rr_pick #(
        .N     (N_REQ - 1),
        .PTR_W (IDX_W)
    ) u_rr_pick (
        .req  (req[N_REQ-1:1]),
        .ptr  (rr_ptr),
        .pick (low_pick)
    );

    always_comb begin
        gnt = '0;
        if (!reset) begin
            if (req[REQ_PIXEL]) begin
                gnt[REQ_PIXEL] = 1'b1;
            end else begin
                gnt[N_REQ-1:1] = low_pick;
            end
        end
    end

    always_comb begin
        gnt_idx  = '0;
        sel_addr = '0;
        sel_elem = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx  = IDX_W'(i);
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_elem = req_elem[i*ELEM_W +: ELEM_W];
            end
        end
    end

    // Issue stage, then the tag rides alongside the memory latency so the
    // owner index lines up with the cycle mem_data is registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= IDX_W'(1);
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            mem_elem  <= '0;
            issue_idx <= '0;
            tag_v     <= '0;
            rd_valid  <= '0;
            rd_data   <= '0;
            for (int s = 0; s < MEM_LAT; s++) begin
                tag_idx[s] <= '0;
            end
        end else begin
            mem_en    <= |gnt;
            issue_idx <= gnt_idx;
            if (|gnt) begin
                mem_addr <= sel_addr;
                mem_elem <= sel_elem;
            end
            if (|gnt[N_REQ-1:1]) begin
                rr_ptr <= IDX_W'(rr_next(int'(gnt_idx), N_REQ));
            end
            tag_v[0]   <= mem_en;
            tag_idx[0] <= issue_idx;
            for (int s = 1; s < MEM_LAT; s++) begin
                tag_v[s]   <= tag_v[s-1];
                tag_idx[s] <= tag_idx[s-1];
            end
            for (int i = 0; i < N_REQ; i++) begin
                rd_valid[i] <= tag_v[MEM_LAT-1] && (tag_idx[MEM_LAT-1] == IDX_W'(i));
            end
            if (tag_v[MEM_LAT-1]) begin
                rd_data <= mem_data;
            end
        end
    end

    assign starve[REQ_PIXEL] = 1'b0;

    // Flag rises on the same edge the wait counter reaches STARVE_MAX.
    for (genvar g = 1; g < N_REQ; g++) begin : g_starve
        logic [CNT_W-1:0] wait_cnt;
        logic             flag;

        always_ff @(posedge clk) begin
            if (reset) begin
                wait_cnt <= '0;
                flag     <= 1'b0;
            end else if (gnt[g]) begin
                wait_cnt <= '0;
            end else if (req[g]) begin
                if (wait_cnt != CNT_W'(STARVE_MAX)) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                if (wait_cnt >= CNT_W'(STARVE_MAX - 1)) begin
                    flag <= 1'b1;
                end
            end
        end

        assign starve[g] = flag;
    end

endmodule
